// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt front end: line count, FSM state
// encoding and the fixed-priority winner encoder.
package irq_pkg;

    localparam int NUM_IRQ = 4;
    localparam int IDX_W   = $clog2(NUM_IRQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_HOLD  = S_HOLD
    } irq_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest-numbered set bit wins (bit0 > bit1 > bit2 > bit3).
    function automatic prio_t prio_enc(input logic [NUM_IRQ-1:0] req);
        prio_t r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: 2-FF synchronizer, optional debounce filter and
// rising-edge detector. Debounce is built only when IRQ_DEBOUNCE_EN is defined.
// All history resets to "high" so a line that is high while reset is
// released can never look like a fresh rising edge.
module irq_sync_edge #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic level;

`ifdef IRQ_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          filt_q, filt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // Filtered level follows the synchronized level only after DEB_CYCLES
    // consecutive samples that differ from it.
    always_comb begin
        filt_d = filt_q;
        dcnt_d = '0;
        if (s2_q != filt_q) begin
            if (dcnt_q == DW'(DEB_CYCLES - 1)) begin
                filt_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_q <= 1'b1;
            dcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_deb;
    assign unused_deb = (DEB_CYCLES > 0);
    assign level      = s2_q;
`endif

    // Next values of the synchronizer chain and edge history.
    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        prev_d = level;
    end

    // Synchronizer and previous-level registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt front end for the single-cycle cpu. Latches rising edges of four
// async request lines as pending and issues one-cycle ie pulses one at a time
// by fixed priority, with HOLDOFF idle cycles after each pulse.
// Optional feature macro: IRQ_DEBOUNCE_EN (per-line debounce, DEB_CYCLES).
// Handshake: there is none back from the cpu; an ie pulse is the whole
// transaction and the hold-off gap gives the cpu time to take its vector.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int HOLDOFF    = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               ov_clr,
    output logic               ie1,
    output logic               ie2,
    output logic               ie3,
    output logic               ie4,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overrun,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] ov_q, ov_d;
    logic [NUM_IRQ-1:0] issued;
    irq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    prio_t              pr;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_sync_edge (
            .clk      (clk),
            .reset    (reset),
            .async_in (irq_in[g]),
            .rise     (rise[g])
        );
    end

    // Mask, pending and overrun next-state. The new mask applies in the same
    // edge, so newly masked lines drop pending and their edges are discarded.
    always_comb begin
        mask_d = mask_we ? mask_in : mask_q;
        issued = (state_q == ST_ISSUE) ? (NUM_IRQ'(1) << winner_q) : '0;
        pend_d = (pend_q & ~issued & ~mask_d) | (rise & ~mask_d);
        ov_d   = (ov_q & ~{NUM_IRQ{ov_clr}}) | (rise & ~mask_d & pend_q & ~issued);
    end

    // FSM next-state: pick a winner in IDLE, pulse in ISSUE, count out HOLD.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        pr       = prio_enc(pend_q & ~mask_q);
        case (state_q)
            ST_IDLE: begin
                if (pr.valid) begin
                    state_d  = ST_ISSUE;
                    winner_d = pr.idx;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CW'(HOLDOFF - 1);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All controller state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q   <= '0;
            pend_q   <= '0;
            ov_q     <= '0;
            state_q  <= ST_IDLE;
            winner_q <= '0;
            cnt_q    <= '0;
        end else begin
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            ov_q     <= ov_d;
            state_q  <= state_d;
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ie1       = issued[0];
    assign ie2       = issued[1];
    assign ie3       = issued[2];
    assign ie4       = issued[3];
    assign pending   = pend_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (HOLDOFF=4, DEB_CYCLES=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_irq_ctrl;

`ifdef IRQ_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       ov_clr;
    logic       ie1, ie2, ie3, ie4;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] ie_v;

    int n_checks = 0;
    int n_errors = 0;

    assign ie_v = {ie4, ie3, ie2, ie1};

    irq_ctrl #(
        .HOLDOFF    (4),
        .DEB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_in   (mask_in),
        .ov_clr    (ov_clr),
        .ie1       (ie1),
        .ie2       (ie2),
        .ie3       (ie3),
        .ie4       (ie4),
        .pending   (pending),
        .overrun   (overrun),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] acc;
        logic [3:0] e;
        int         cnt;
        int         k;
        bit         bsy;

        reset   = 1'b0;
        irq_in  = 4'b0000;
        mask_we = 1'b0;
        mask_in = 4'b0000;
        ov_clr  = 1'b0;
        tick();
        tick();
        check("rst_ie", ie_v, 4'b0000);
        check("rst_pending", pending, 4'b0000);
        check("rst_overrun", overrun, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("idle_busy", busy, 1'b0);

        // 1: single request on line 2
        irq_in = 4'b0100;
        repeat (3 + D) tick();
        check("t1_pend_set", pending, 4'b0100);
        check("t1_no_ie_yet", ie_v, 4'b0000);
        tick();
        check("t1_ie3", ie_v, 4'b0100);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_ie_off", ie_v, 4'b0000);
        check("t1_pend_clr", pending, 4'b0000);
        cnt = 0;
        repeat (10) begin
            tick();
            if (ie_v != 4'b0000) cnt++;
        end
        check("t1_extra_pulses", cnt, 0);
        check("t1_idle", busy, 1'b0);
        irq_in = 4'b0000;
        repeat (10) tick();

        // 2: all four at once, priority order, HOLDOFF+2 spacing
        irq_in = 4'b1111;
        for (int t = 1; t <= 30; t++) begin
            tick();
            k = t - (4 + D);
            e = 4'b0000;
            if (k >= 0 && k <= 18 && (k % 6) == 0) e = 4'(1 << (k / 6));
            check("t2_ie", ie_v, e);
            bsy = (k >= 0 && k <= 22 && (k % 6) != 5);
            check("t2_busy", busy, bsy);
            if (t == 3 + D) check("t2_pend_all", pending, 4'b1111);
        end
        check("t2_pend_end", pending, 4'b0000);
        irq_in = 4'b0000;
        repeat (10) tick();

`ifndef IRQ_DEBOUNCE_EN
        // 3: two edges on line 0 while its first pulse is in hold-off
        for (int t = 0; t < 20; t++) begin
            irq_in[0] = (t == 2 || t == 4) ? 1'b0 : 1'b1;
            tick();
            e = (t + 1 == 4 || t + 1 == 10) ? 4'b0001 : 4'b0000;
            check("t3_ie", ie_v, e);
            if (t + 1 == 6) check("t3_pend_in_hold", pending, 4'b0001);
            if (t + 1 == 8) check("t3_overrun_set", overrun, 4'b0001);
        end
        check("t3_overrun_sticky", overrun, 4'b0001);
        check("t3_pend_end", pending, 4'b0000);
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        check("t3_ov_clr", overrun, 4'b0000);
        irq_in = 4'b0000;
        repeat (10) tick();
`endif

        // 4a: masked line 1 never latches
        mask_we = 1'b1;
        mask_in = 4'b0010;
        tick();
        mask_we = 1'b0;
        mask_in = 4'b0000;
        irq_in  = 4'b0010;
        acc = 4'b0000;
        repeat (12 + D) begin
            tick();
            acc |= ie_v;
        end
        check("t4_no_ie2", acc, 4'b0000);
        check("t4_pend1", pending, 4'b0000);

        // 4b: pending[3] latched during hold-off, then masked away
        irq_in[0] = 1'b1;
        acc = 4'b0000;
        for (int t = 1; t <= 20; t++) begin
            if (t == 3) irq_in[3] = 1'b1;
            tick();
            if (t == 4 + D) check("t4_ie1", ie_v, 4'b0001);
            if (t >= 5 + D) acc |= ie_v;
            if (t == 5 + D) begin
                check("t4_pend3_set", pending, 4'b1000);
                mask_we = 1'b1;
                mask_in = 4'b1010;
            end
            if (t == 6 + D) begin
                check("t4_pend3_clr", pending, 4'b0000);
                mask_we = 1'b0;
            end
        end
        check("t4_no_ie4", acc, 4'b0000);
        mask_we = 1'b1;
        mask_in = 4'b0000;
        tick();
        mask_we = 1'b0;
        irq_in  = 4'b0000;
        repeat (10) tick();

        // 5: reset during HOLD; lines high through reset give no pulse
        irq_in = 4'b0001;
        repeat (4 + D) tick();
        check("t5_ie1", ie_v, 4'b0001);
        tick();
        irq_in = 4'b0101;
        tick();
        check("t5_busy_hold", busy, 1'b1);
        reset = 1'b0;
        tick();
        check("t5_rst_ie", ie_v, 4'b0000);
        check("t5_rst_pending", pending, 4'b0000);
        check("t5_rst_overrun", overrun, 4'b0000);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_state", state_dbg, 2'd0);
        reset = 1'b1;
        acc = 4'b0000;
        repeat (15 + D) begin
            tick();
            acc |= ie_v;
        end
        check("t5_no_pulse", acc, 4'b0000);
        check("t5_pend", pending, 4'b0000);
        irq_in = 4'b0000;
        repeat (10) tick();

`ifdef IRQ_DEBOUNCE_EN
        // 6: 3-cycle glitch ignored, 6-cycle pulse gives one delayed ie1
        irq_in = 4'b0001;
        acc = 4'b0000;
        for (int t = 1; t <= 20; t++) begin
            if (t == 4) irq_in = 4'b0000;
            tick();
            acc |= ie_v;
        end
        check("t6_glitch", acc, 4'b0000);
        irq_in = 4'b0001;
        for (int t = 1; t <= 20; t++) begin
            if (t == 7) irq_in = 4'b0000;
            tick();
            e = (t == 8) ? 4'b0001 : 4'b0000;
            check("t6_ie", ie_v, e);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
